// File: rtl/dp_bram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port block RAM.
package dp_bram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RDW_READ_OLD    = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int num_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dp_bram_lane.sv
// One byte lane of the RAM: DEPTH x BYTE_WIDTH array with a registered, enabled read.
module dp_bram_lane #(
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [BYTE_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [BYTE_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BYTE_WIDTH-1:0] mem_q [DEPTH];
  logic [BYTE_WIDTH-1:0] rdata_q;

  // Array has no reset so it maps onto block RAM; contents come from the sweep.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dp_bram_be.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, selectable
// read-during-write behaviour and a zeroing sweep after reset.
module dp_bram_be
  import dp_bram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          rd_en,
  input  logic [ADDR_WIDTH-1:0]                         raddr,
  input  logic                                          wr_en,
  input  logic [ADDR_WIDTH-1:0]                         waddr,
  input  logic [num_lanes(DATA_WIDTH, BYTE_WIDTH)-1:0]  wr_be,
  input  logic [DATA_WIDTH-1:0]                         data_in,
  output logic [DATA_WIDTH-1:0]                         data_out,
  output logic                                          rd_valid,
  output logic                                          init_busy
);

  localparam int NUM_LANES = num_lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam bit FWD_EN = (RDW_MODE == RDW_WRITE_FIRST);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("dp_bram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("dp_bram_be: READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_READ_OLD && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $error("dp_bram_be: RDW_MODE must be 0 or 1");
  end

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign init_busy = busy_q;

  logic rd_acc;
  logic wr_acc;
  logic collide;

  assign rd_acc  = rd_en & ~busy_q;
  assign wr_acc  = wr_en & ~busy_q;
  assign collide = FWD_EN & rd_acc & wr_acc & (raddr == waddr);

  logic [NUM_LANES-1:0]                 lane_we;
  logic [ADDR_WIDTH-1:0]                lane_waddr;
  logic [NUM_LANES-1:0][BYTE_WIDTH-1:0] lane_wdata;
  logic [NUM_LANES-1:0][BYTE_WIDTH-1:0] lane_rdata;

  // The sweep owns the write port while busy and writes zero to every lane.
  always_comb begin
    lane_waddr = busy_q ? cnt_q : waddr;
    lane_we    = '0;
    lane_wdata = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_we[i]    = busy_q | (wr_acc & wr_be[i]);
      lane_wdata[i] = busy_q ? '0 : data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dp_bram_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .we_i    (lane_we[g]),
      .waddr_i (lane_waddr),
      .wdata_i (lane_wdata[g]),
      .re_i    (rd_acc),
      .raddr_i (raddr),
      .rdata_o (lane_rdata[g])
    );
  end

  // Forwarding state is captured only on accepted reads so data_out holds between reads.
  logic [NUM_LANES-1:0]  fwd_be_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic                  v1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
      v1_q       <= 1'b0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        fwd_be_q   <= collide ? wr_be : '0;
        fwd_data_q <= data_in;
      end
    end
  end

  logic [DATA_WIDTH-1:0] word_d;

  always_comb begin
    word_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      word_d[i*BYTE_WIDTH +: BYTE_WIDTH] = fwd_be_q[i] ? fwd_data_q[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                       : lane_rdata[i];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  v2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        v2_q   <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          dout_q <= word_d;
        end
      end
    end

    assign data_out = dout_q;
    assign rd_valid = v2_q;
  end else begin : g_lat1
    assign data_out = word_d;
    assign rd_valid = v1_q;
  end

endmodule

// File: tb/tb_dp_bram_be.sv
// Scoreboarded bench for dp_bram_be: one instance per latency / read-during-write mode.
module tb_dp_bram_be;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [3:0]  raddr = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  waddr = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] data_in = '0;

  logic [15:0] dout_a, dout_b;
  logic        val_a, val_b, busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] mem_m [16];
  logic        m_run = 1'b0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  // Latency 1, read-old
  dp_bram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .READ_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .raddr(raddr), .wr_en(wr_en), .waddr(waddr),
    .wr_be(wr_be), .data_in(data_in), .data_out(dout_a), .rd_valid(val_a), .init_busy(busy_a));

  // Latency 2, write-first
  dp_bram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .READ_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .raddr(raddr), .wr_en(wr_en), .waddr(waddr),
    .wr_be(wr_be), .data_in(data_in), .data_out(dout_b), .rd_valid(val_b), .init_busy(busy_b));

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: sweep, memory and expected read results, evaluated on pre-edge inputs.
  always @(posedge clk or posedge rst) begin
    exp_t        e;
    logic [15:0] old_w, mrg;
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      qa.delete();
      qb.delete();
    end else if (!m_run) begin
      mem_m[m_cnt] = 16'h0000;
      if (m_cnt == 15) m_run = 1'b1;
      else m_cnt = m_cnt + 1;
    end else begin
      if (rd_en) begin
        old_w = mem_m[raddr];
        mrg   = old_w;
        if (wr_en && waddr == raddr) begin
          if (wr_be[0]) mrg[7:0]  = data_in[7:0];
          if (wr_be[1]) mrg[15:8] = data_in[15:8];
        end
        e.data = old_w; e.due = cyc + 1; qa.push_back(e);
        e.data = mrg;   e.due = cyc + 2; qb.push_back(e);
      end
      if (wr_en) begin
        if (wr_be[0]) mem_m[waddr][7:0]  = data_in[7:0];
        if (wr_be[1]) mem_m[waddr][15:8] = data_in[15:8];
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (val_a) begin
        n_tests++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a_spurious: rd_valid=1 data=%h at cycle %0d, required no valid", dout_a, cyc);
        end else begin
          e = qa.pop_front();
          if (dout_a !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL sb_a_data: got %h at cycle %0d, required %h at cycle %0d", dout_a, cyc, e.data, e.due);
          end
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        n_tests++; n_fail++;
        e = qa.pop_front();
        $display("FAIL sb_a_missing: rd_valid=0 at cycle %0d, required valid with %h", cyc, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (val_b) begin
        n_tests++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b_spurious: rd_valid=1 data=%h at cycle %0d, required no valid", dout_b, cyc);
        end else begin
          e = qb.pop_front();
          if (dout_b !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL sb_b_data: got %h at cycle %0d, required %h at cycle %0d", dout_b, cyc, e.data, e.due);
          end
        end
      end else if (qb.size() != 0 && qb[0].due <= cyc) begin
        n_tests++; n_fail++;
        e = qb.pop_front();
        $display("FAIL sb_b_missing: rd_valid=0 at cycle %0d, required valid with %h", cyc, e.data);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  task automatic op(input logic rd, input logic [3:0] ra, input logic wr, input logic [3:0] wa,
                    input logic [1:0] be, input logic [15:0] di);
    @(negedge clk);
    rd_en = rd; raddr = ra; wr_en = wr; waddr = wa; wr_be = be; data_in = di;
  endtask

  // Count negedges until init_busy falls; returns 99 if it never does.
  task automatic sweep_len(output int n);
    n = 0;
    while (busy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy_a) n = 99;
  endtask

  task automatic test_reset;
    int n;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    n_tests++;
    if (dout_a !== 16'h0 || val_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a: data_out=%h rd_valid=%b init_busy=%b, required 0000 0 1", dout_a, val_a, busy_a);
    end
    n_tests++;
    if (dout_b !== 16'h0 || val_b !== 1'b0 || busy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_b: data_out=%h rd_valid=%b init_busy=%b, required 0000 0 1", dout_b, val_b, busy_b);
    end
    rst = 1'b0;
    sweep_len(n);
    n_tests++;
    if (n != 16 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sweep_len: init_busy high for %0d edges (b=%b), required 16", n, busy_b);
    end
  endtask

  task automatic test_sweep_zero;
    for (int a = 0; a < 16; a++) op(1'b1, 4'(a), 1'b0, 4'd0, 2'b00, 16'h0);
    idle(4);
    n_tests++;
    if (dout_a !== 16'h0000 || dout_b !== 16'h0000) begin
      n_fail++;
      $display("FAIL sweep_zero_hold: a=%h b=%h, required 0000", dout_a, dout_b);
    end
  endtask

  task automatic test_byte_enable;
    op(1'b0, 4'd0, 1'b1, 4'd3, 2'b11, 16'hABCD);
    op(1'b0, 4'd0, 1'b1, 4'd3, 2'b01, 16'h1234);
    op(1'b0, 4'd0, 1'b1, 4'd3, 2'b00, 16'hFFFF);
    op(1'b1, 4'd3, 1'b0, 4'd0, 2'b00, 16'h0);
    idle(4);
    n_tests++;
    if (dout_a !== 16'hAB34 || dout_b !== 16'hAB34) begin
      n_fail++;
      $display("FAIL byte_enable: a=%h b=%h, required AB34", dout_a, dout_b);
    end
  endtask

  task automatic test_collision;
    op(1'b0, 4'd0, 1'b1, 4'd5, 2'b11, 16'h1111);
    op(1'b1, 4'd5, 1'b1, 4'd5, 2'b11, 16'h2222);
    idle(4);
    n_tests++;
    if (dout_a !== 16'h1111 || dout_b !== 16'h2222) begin
      n_fail++;
      $display("FAIL collision_full: a=%h b=%h, required 1111 2222", dout_a, dout_b);
    end
    op(1'b1, 4'd5, 1'b0, 4'd0, 2'b00, 16'h0);
    idle(4);
    n_tests++;
    if (dout_a !== 16'h2222 || dout_b !== 16'h2222) begin
      n_fail++;
      $display("FAIL collision_after: a=%h b=%h, required 2222", dout_a, dout_b);
    end
    op(1'b0, 4'd0, 1'b1, 4'd5, 2'b11, 16'h1111);
    op(1'b1, 4'd5, 1'b1, 4'd5, 2'b10, 16'h2222);
    // Later port activity must not disturb the in-flight merged result.
    op(1'b0, 4'd0, 1'b1, 4'd5, 2'b11, 16'h7777);
    idle(4);
    n_tests++;
    if (dout_a !== 16'h1111 || dout_b !== 16'h2211) begin
      n_fail++;
      $display("FAIL collision_lane: a=%h b=%h, required 1111 2211", dout_a, dout_b);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] vals [3];
    logic        ev;
    vals[0] = 16'hC0C0; vals[1] = 16'hC1C1; vals[2] = 16'hC2C2;
    for (int i = 0; i < 3; i++) op(1'b0, 4'd0, 1'b1, 4'(i), 2'b11, vals[i]);
    idle(4);
    op(1'b1, 4'd0, 1'b0, 4'd0, 2'b00, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 3) raddr = 4'(k);
      else rd_en = 1'b0;
      ev = (k >= 2 && k <= 4);
      n_tests++;
      if (val_b !== ev || (ev && dout_b !== vals[k-2])) begin
        n_fail++;
        $display("FAIL b2b_lat2_k%0d: rd_valid=%b data=%h, required rd_valid=%b data=%h",
                 k, val_b, dout_b, ev, ev ? vals[k-2] : dout_b);
      end
    end
    idle(3);
  endtask

  task automatic test_reset_midsweep;
    int n;
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(7);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    sweep_len(n);
    n_tests++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL midsweep_restart: init_busy high for %0d edges, required 16", n);
    end
    op(1'b1, 4'd3, 1'b0, 4'd0, 2'b00, 16'h0);
    @(negedge clk);
    rd_en = 1'b0;
    rst = 1'b1;
    idle(1);
    n_tests++;
    if (val_b !== 1'b0 || dout_b !== 16'h0 || dout_a !== 16'h0) begin
      n_fail++;
      $display("FAIL pending_reset: b valid=%b data=%h a data=%h, required 0 0000 0000", val_b, dout_b, dout_a);
    end
    rst = 1'b0;
    sweep_len(n);
    n_tests++;
    if (n != 16 || dout_b !== 16'h0) begin
      n_fail++;
      $display("FAIL pending_reset_after: sweep %0d edges data_b=%h, required 16 0000", n, dout_b);
    end
  endtask

  task automatic test_init_ignore;
    int nv;
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      op(1'b1, 4'd9, 1'b1, 4'(9 + (i % 2)), 2'b11, 16'hFFFF);
      if (val_a || val_b) nv++;
    end
    idle(8);
    n_tests++;
    if (nv != 0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL init_ignore: %0d valids during sweep, busy=%b, required 0 0", nv, busy_a);
    end
    op(1'b1, 4'd9, 1'b0, 4'd0, 2'b00, 16'h0);
    op(1'b1, 4'd10, 1'b0, 4'd0, 2'b00, 16'h0);
    idle(4);
    n_tests++;
    if (dout_a !== 16'h0 || dout_b !== 16'h0) begin
      n_fail++;
      $display("FAIL init_ignore_mem: a=%h b=%h, required 0000", dout_a, dout_b);
    end
  endtask

  task automatic test_random_traffic;
    for (int i = 0; i < 200; i++) begin
      op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
         4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom));
    end
    idle(5);
  endtask

  task automatic test_drain;
    idle(3);
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expected reads outstanding, required 0/0", qa.size(), qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_sweep_zero();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_random_traffic();
    test_reset_midsweep();
    test_init_ignore();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dp_bram_be.md
# dp_bram_be

Parametrised simple-dual-port block RAM: one write port with byte enables and one read port with read enable. It adds a selectable 1- or 2-cycle read latency, a read-valid strobe, a selectable read-during-write mode, and a post-reset zeroing sweep. It replaces the plain two-address buffer RAM in the accelerator's datapath wherever partial-word updates, deeper timing closure or deterministic post-reset contents are needed.

## Interface
- ADDR_WIDTH, 4: address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16: word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: lane width per write-enable bit; NUM_LANES = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1: 1 or 2 cycles from rd_en to data_out.
- RDW_MODE, 0: same-address read/write in one cycle; 0 = read-old, 1 = write-first (forward merged new data).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  read request.
- raddr  in  ADDR_WIDTH  read address.
- wr_en  in  1  write request.
- waddr  in  ADDR_WIDTH  write address.
- wr_be  in  NUM_LANES  per-lane write enable; bit i covers data_in[i*BYTE_WIDTH +: BYTE_WIDTH].
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data; holds its last value when rd_valid=0.
- rd_valid  out  1  data_out carries the result of an accepted read this cycle.
- init_busy  out  1  zeroing sweep in progress; the ports are ignored while high.

## Operation
- Illegal parameters (DATA_WIDTH % BYTE_WIDTH ≠ 0, READ_LATENCY ∉ {1,2}, RDW_MODE ∉ {0,1}) cause an elaboration error.
- FSM states: INIT and RUN.
  - rst forces INIT with the sweep counter at 0.
  - In INIT, each cycle writes all-zero (all lanes) to mem[counter], then increments the counter.
  - After the write to DEPTH-1, the FSM moves to RUN.
  - RUN holds until rst.
- In INIT, rd_en and wr_en are ignored and no rd_valid is produced.
- Write in RUN: when wr_en=1, mem[waddr] lane i ← data_in lane i for each i with wr_be[i]=1. Other lanes are unchanged. wr_be=0 is a no-op.
- Read in RUN: rd_en=1 samples raddr. The result appears after READ_LATENCY edges with rd_valid=1 for exactly one cycle.
  - Back-to-back reads are accepted every cycle; throughput is 1 per cycle.
- Collision (rd_en, wr_en, raddr==waddr in the same cycle):
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns a per-lane merge, taking data_in for enabled lanes and the old word otherwise.
- A write at cycle t is visible to a read issued at cycle t+1 or later in both modes.
- The memory array itself is never reset; only the sweep clears it.

## Timing
- Reset values: data_out=0, rd_valid=0, init_busy=1, sweep counter=0, all read-pipeline valid bits 0.
- init_busy is 1 from rst assertion through the cycle that writes DEPTH-1. It falls after exactly DEPTH rising edges following rst deassertion (16 with defaults).
- rst during the sweep restarts it from address 0.
- rst during RUN discards in-flight reads: no rd_valid is produced for them, even after release.
- READ_LATENCY=1, rd_en at cycle t: data_out and rd_valid are valid in cycle t+1.
- READ_LATENCY=2, rd_en at cycle t: the RAM output register is updated at the t+1 edge. data_out and rd_valid are valid in cycle t+2 through a second register.
- Collision forwarding uses the data_in/wr_be values sampled in the request cycle. Later port activity does not alter an in-flight result.
- Address wrap: none. Any raddr/waddr in 0..DEPTH-1 is legal.

## Structure
- Package dp_bram_pkg holds:
  - the FSM state enum (ST_INIT, ST_RUN);
  - constants RDW_READ_OLD=0 and RDW_WRITE_FIRST=1;
  - a function computing NUM_LANES.
- Sub-module dp_bram_lane: one BYTE_WIDTH-wide, DEPTH-deep array with its own write enable and a registered read. It is instantiated NUM_LANES times via generate.
- The top level holds:
  - the sweep FSM and counter;
  - the write-address mux between sweep and user writes;
  - collision detect and merge;
  - the optional second output stage.

## Test plan
- Reset release, defaults: init_busy stays 1 for 16 cycles then 0. Reads of addresses 0..15 all return 0x0000 with rd_valid 1 cycle later.
- Write 0xABCD to addr 3 with wr_be=2'b11, then wr_be=2'b01 with data 0x1234: a read of addr 3 returns 0xAB34.
- RDW_MODE=0, addr 5 holds 0x1111: a same-cycle write of 0x2222 with read of 5 returns 0x1111; the next read returns 0x2222. RDW_MODE=1 with wr_be=2'b10 returns 0x2211.
- READ_LATENCY=2, reads of addresses 0,1,2 on consecutive cycles: rd_valid is high on cycles t+2..t+4 with data in order; rd_valid is low otherwise.
- rst pulsed mid-sweep (counter=7) and again during a pending 2-cycle read: the sweep restarts (16 more cycles of init_busy), no stale rd_valid appears, and data_out=0.
- Reads and writes issued while init_busy=1 are ignored: no rd_valid is produced, and the target addresses still read 0 after the sweep.
